// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, result codes,
// default cycle counts at 50 MHz and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRelease,
        StData,
        StAck,
        StWaitIdle,
        StError
    } ps2_tx_state_e;

    localparam logic [1:0] PS2_ERR_OK     = 2'b00;
    localparam logic [1:0] PS2_ERR_NORESP = 2'b01;
    localparam logic [1:0] PS2_ERR_PKT    = 2'b10;
    localparam logic [1:0] PS2_ERR_NOACK  = 2'b11;

    // 120 us request-to-send, 15 ms first-clock wait, 2 ms packet budget
    localparam int unsigned PS2_INHIBIT_CYCLES = 6000;
    localparam int unsigned PS2_RESP_TIMEOUT   = 750000;
    localparam int unsigned PS2_PKT_TIMEOUT    = 100000;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe.
// Flops reset to 1 (idle line) so leaving reset never fakes an edge.
module ps2_line_sync (
    input  logic clock,
    input  logic resetn,
    input  logic line_in,
    output logic line_sync,
    output logic fell
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronize the pin and keep one cycle of history for edge detection
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign line_sync = sync_q;
    assign fell      = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain lines via oe.
// Optional macro PS2_TX_TIMEOUT_EN: enables response/packet timeouts
// (err 01/10) and the cycle bound on the ERROR exit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
    parameter int unsigned RESP_TIMEOUT   = PS2_RESP_TIMEOUT,
    parameter int unsigned PKT_TIMEOUT    = PS2_PKT_TIMEOUT
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    localparam int unsigned CntMax0 = (INHIBIT_CYCLES > RESP_TIMEOUT) ? INHIBIT_CYCLES
                                                                      : RESP_TIMEOUT;
    localparam int unsigned CntMax  = (CntMax0 > PKT_TIMEOUT) ? CntMax0 : PKT_TIMEOUT;
    localparam int unsigned CntW    = $clog2(CntMax + 2);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    ps2_tx_state_e   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic [1:0]      err_q, err_d;

    logic clk_s, clk_fe, data_s, data_fe_unused;
    logic lines_high;
    logic resp_expired, pkt_expired, err_bound;

    ps2_line_sync u_clk_sync (
        .clock     (clock),
        .resetn    (resetn),
        .line_in   (ps2_clk_in),
        .line_sync (clk_s),
        .fell      (clk_fe)
    );

    ps2_line_sync u_data_sync (
        .clock     (clock),
        .resetn    (resetn),
        .line_in   (ps2_data_in),
        .line_sync (data_s),
        .fell      (data_fe_unused)
    );

    assign lines_high = clk_s & data_s;

`ifdef PS2_TX_TIMEOUT_EN
    assign resp_expired = (cnt_q == CntW'(RESP_TIMEOUT - 1));
    assign pkt_expired  = (cnt_q == CntW'(PKT_TIMEOUT - 1));
    assign err_bound    = (cnt_q == CntW'(INHIBIT_CYCLES - 1));
`else
    assign resp_expired = 1'b0;
    assign pkt_expired  = 1'b0;
    assign err_bound    = 1'b0;
`endif

    // State, datapath and registered line-enable flops
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= PS2_ERR_OK;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            err_q     <= err_d;
        end
    end

    // Next-state, next line enables and the done strobe
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        err_d     = err_q;
        done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    state_d  = StInhibit;
                    shift_d  = tx_data;
                    par_d    = odd_parity(tx_data);
                    err_d    = PS2_ERR_OK;
                    bit_d    = '0;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                end
            end
            StInhibit: begin
                // Device edges seen here are our own clock pull-down; ignore them
                cnt_d = cnt_q + CntOne;
                if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                end
                if (cnt_q == CntW'(INHIBIT_CYCLES)) begin
                    state_d  = StRelease;
                    clk_oe_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            StRelease: begin
                // Timeout takes priority over a coincident device edge
                if (resp_expired) begin
                    state_d   = StError;
                    err_d     = PS2_ERR_NORESP;
                    data_oe_d = 1'b0;
                    cnt_d     = '0;
                end else if (clk_fe) begin
                    state_d   = StData;
                    data_oe_d = ~shift_q[0];
                    bit_d     = 4'd1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StData: begin
                if (pkt_expired) begin
                    state_d   = StError;
                    err_d     = PS2_ERR_PKT;
                    data_oe_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                    if (clk_fe) begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q < 4'd8) begin
                            data_oe_d = ~shift_q[bit_q[2:0]];
                        end else if (bit_q == 4'd8) begin
                            data_oe_d = ~par_q;
                        end else begin
                            // Stop bit: release data and let the device ACK
                            data_oe_d = 1'b0;
                            state_d   = StAck;
                        end
                    end
                end
            end
            StAck: begin
                if (pkt_expired) begin
                    state_d = StError;
                    err_d   = PS2_ERR_PKT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                    if (clk_fe) begin
                        if (data_s) begin
                            state_d = StError;
                            err_d   = PS2_ERR_NOACK;
                            cnt_d   = '0;
                        end else begin
                            state_d = StWaitIdle;
                        end
                    end
                end
            end
            StWaitIdle: begin
                if (lines_high) begin
                    done    = 1'b1;
                    err_d   = PS2_ERR_OK;
                    state_d = StIdle;
                end
            end
            StError: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                cnt_d     = cnt_q + CntOne;
                if (lines_high || err_bound) begin
                    done    = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d   = StIdle;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        endcase
    end

    assign tx_ready    = (state_q == StIdle);
    assign busy        = ~tx_ready;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: table of command bytes with a
// device model on the wired-AND lines, plus reset and no-response sequences.
module tb_ps2_host_tx;

    localparam int unsigned IC = 20;
    localparam int unsigned RT = 300;
    localparam int unsigned PT = 1000;
    localparam int          H  = 10;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       busy, done;
    logic [1:0] err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    // Open-drain lines with pull-ups: low if either side pulls
    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES (IC),
        .RESP_TIMEOUT   (RT),
        .PKT_TIMEOUT    (PT)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Accept a byte and wait for the host to release the clock line
    task automatic start_txn(input logic [7:0] d, input logic intrude,
                             output logic oe_after, output logic start_bit,
                             output logic ok);
        ok        = 1'b0;
        start_bit = 1'bx;
        @(negedge clock);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clock);
        oe_after = ps2_clk_oe;
        tx_valid = 1'b0;
        for (int i = 0; i < int'(IC) + 20; i++) begin
            if (intrude && i == 0) begin
                tx_data  = 8'h00;
                tx_valid = 1'b1;
            end else if (intrude && i == 1) begin
                tx_valid = 1'b0;
            end
            if (!ps2_clk_oe && i > 0) begin
                ok        = 1'b1;
                start_bit = ps2_data_in;
                break;
            end
            @(negedge clock);
        end
        tx_valid = 1'b0;
    endtask

    // Device clocks nclk pulses, sampling data on each rising edge
    task automatic dev_frame(input logic ack, input int nclk, output logic [9:0] frame);
        frame = '0;
        for (int i = 0; i < nclk; i++) begin
            repeat (H) @(negedge clock);
            dev_clk = 1'b0;
            repeat (H) @(negedge clock);
            if (i < 10) frame[i] = ps2_data_in;
            dev_clk = 1'b1;
            if (i == 9 && ack) dev_data = 1'b0;
            if (i == 10) dev_data = 1'b1;
        end
    endtask

    task automatic wait_done(output logic got, output logic [1:0] e);
        got = 1'b0;
        e   = 2'bxx;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (done) begin
                got = 1'b1;
                e   = err;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       intrude;
        logic [9:0] frame;   // {stop, parity, data}
        logic [1:0] err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic       oe_after, start_bit, ok, got;
        logic [9:0] frame;
        logic [1:0] e;
        int         n;
        int         dones;

        vecs[0] = '{data: 8'hED, ack: 1'b1, intrude: 1'b0, frame: 10'h3ED, err: 2'b00};
        vecs[1] = '{data: 8'hF4, ack: 1'b1, intrude: 1'b0, frame: 10'h2F4, err: 2'b00};
        vecs[2] = '{data: 8'hFF, ack: 1'b0, intrude: 1'b0, frame: 10'h3FF, err: 2'b11};
        vecs[3] = '{data: 8'hFF, ack: 1'b1, intrude: 1'b1, frame: 10'h3FF, err: 2'b00};
        vecs[4] = '{data: 8'h00, ack: 1'b1, intrude: 1'b0, frame: 10'h300, err: 2'b00};

        repeat (3) @(negedge clock);
        check("reset tx_ready", 32'(tx_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge clock);

        for (int v = 0; v < 5; v++) begin
            check($sformatf("v%0d ready before", v), 32'(tx_ready), 32'd1);
            start_txn(vecs[v].data, vecs[v].intrude, oe_after, start_bit, ok);
            check($sformatf("v%0d clk_oe after accept", v), 32'(oe_after), 32'd1);
            check($sformatf("v%0d clock released", v), 32'(ok), 32'd1);
            check($sformatf("v%0d start bit", v), 32'(start_bit), 32'd0);
            dev_frame(vecs[v].ack, 11, frame);
            check($sformatf("v%0d line frame", v), 32'(frame), 32'(vecs[v].frame));
            wait_done(got, e);
            check($sformatf("v%0d done", v), 32'(got), 32'd1);
            check($sformatf("v%0d err", v), 32'(e), 32'(vecs[v].err));
            @(negedge clock);
            check($sformatf("v%0d ready after", v), 32'(tx_ready), 32'd1);
            check($sformatf("v%0d oe idle", v), 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
            repeat (3) @(negedge clock);
            check($sformatf("v%0d err held", v), 32'(err), 32'(vecs[v].err));
        end

        // Asynchronous reset while bit 4 (a 0 for 0xED) is on the line
        start_txn(8'hED, 1'b0, oe_after, start_bit, ok);
        check("rst clock released", 32'(ok), 32'd1);
        dev_frame(1'b1, 5, frame);
        check("rst bit4 driven low", 32'(ps2_data_oe), 32'd1);
        #2 resetn = 1'b0;
        #1 check("rst oe released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("rst tx_ready", 32'(tx_ready), 32'd1);
        check("rst err", 32'(err), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);

        // Device never clocks
        start_txn(8'hF4, 1'b0, oe_after, start_bit, ok);
        check("noresp clock released", 32'(ok), 32'd1);
`ifdef PS2_TX_TIMEOUT_EN
        n = 0;
        while (ps2_data_oe && n < int'(RT) + 50) begin
            @(negedge clock);
            n++;
        end
        check("noresp timeout cycles", 32'(n), 32'(RT));
        wait_done(got, e);
        check("noresp done", 32'(got), 32'd1);
        check("noresp err", 32'(e), 32'd1);
`else
        dones = 0;
        for (int i = 0; i < int'(RT) + 100; i++) begin
            @(negedge clock);
            if (done) dones++;
        end
        check("noresp no done", 32'(dones), 32'd0);
        check("noresp still busy", 32'(busy), 32'd1);
        dev_frame(1'b1, 11, frame);
        check("late frame", 32'(frame), 32'h2F4);
        wait_done(got, e);
        check("late done", 32'(got), 32'd1);
        check("late err", 32'(e), 32'd0);
`endif
        @(negedge clock);
        check("final oe idle", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
